// File: rtl/gtf_drp_pkg.sv
// Shared types and constants for the GTF_COMMON DRP initiator.
package gtf_drp_pkg;
  localparam int DRP_AW = 16;
  localparam int DRP_DW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_EN   = 3'd1,
    RD_WAIT = 3'd2,
    WR_EN   = 3'd3,
    WR_WAIT = 3'd4,
    RSP     = 3'd5
  } drp_state_e;

  // Width that can hold a count of 0..cycles inclusive.
  function automatic int tmr_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/gtf_common_drp_master_if.sv
// Request/response handshake between the register bridge (master) and the DRP initiator (slave).
interface gtf_common_drp_master_if;
  import gtf_drp_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DRP_AW-1:0] req_addr;
  logic [DRP_DW-1:0] req_wdata;
  logic [DRP_DW-1:0] req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DRP_DW-1:0] rsp_rdata;
  logic              rsp_timeout;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout
  );
endinterface

// File: rtl/gtf_drp_timer.sv
// DRP completion watchdog: cleared during the enable cycle, counts while waiting,
// flags the cycle in which the count reaches TIMEOUT_CYCLES.
module gtf_drp_timer
  import gtf_drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int           W    = tmr_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  // High in the wait cycle whose increment lands on the limit.
  assign expired = en && (cnt == LAST);
endmodule

// File: rtl/gtf_common_drp_master.sv
// DRP initiator for GTF_COMMON: single read / write / masked RMW per request.
// Optional feature macro: GTF_DRP_RMW_EN (masked writes become read-modify-write).
module gtf_common_drp_master
  import gtf_drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  gtf_cm_drpclk,
  input  logic                  gtf_cm_drprst_n,
  gtf_common_drp_master_if.slave bus,
  output logic                  gtf_cm_drpen,
  output logic                  gtf_cm_drpwe,
  output logic [DRP_AW-1:0]     gtf_cm_drpaddr,
  output logic [DRP_DW-1:0]     gtf_cm_drpdi,
  input  logic [DRP_DW-1:0]     gtf_cm_drpdo,
  input  logic                  gtf_cm_drprdy,
  output logic                  stray_rdy
);
  drp_state_e        state, state_nxt;
  logic              rst_done;
  logic              accept;
  logic              in_wait;
  logic              expired;
  logic              rmw_req;
  logic              rmw_q;
  logic [DRP_DW-1:0] rdata_q;
  logic              timeout_q;

  assign in_wait       = (state == RD_WAIT) || (state == WR_WAIT);
  assign gtf_cm_drpen  = (state == RD_EN) || (state == WR_EN);
  assign gtf_cm_drpwe  = (state == WR_EN);
  assign bus.req_ready = rst_done && (state == IDLE);
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_timeout = timeout_q;
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef GTF_DRP_RMW_EN
  logic [DRP_DW-1:0] mask_q;

  assign rmw_req = bus.req_we && (bus.req_mask != '1);

  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_drprst_n) begin
    if (!gtf_cm_drprst_n) begin
      mask_q <= '0;
      rmw_q  <= 1'b0;
    end else if (accept) begin
      mask_q <= bus.req_mask;
      rmw_q  <= rmw_req;
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^bus.req_mask;
  assign rmw_req     = 1'b0;
  assign rmw_q       = 1'b0;
`endif

  gtf_drp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (gtf_cm_drpclk),
    .rst_n   (gtf_cm_drprst_n),
    .clr     (gtf_cm_drpen),
    .en      (in_wait),
    .expired (expired)
  );

  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_drprst_n) begin
    if (!gtf_cm_drprst_n) state <= IDLE;
    else                  state <= state_nxt;
  end

  // Completion wins over expiry when both land in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (!bus.req_we || rmw_req) ? RD_EN : WR_EN;
      RD_EN:   state_nxt = RD_WAIT;
      RD_WAIT: if (gtf_cm_drprdy) state_nxt = rmw_q ? WR_EN : RSP;
               else if (expired) state_nxt = RSP;
      WR_EN:   state_nxt = WR_WAIT;
      WR_WAIT: if (gtf_cm_drprdy || expired) state_nxt = RSP;
      RSP:     if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // drpdi doubles as the write-data holding register; an RMW overwrites it
  // with the merged value between the read completion and the write enable.
  always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_drprst_n) begin
    if (!gtf_cm_drprst_n) begin
      rst_done       <= 1'b0;
      gtf_cm_drpaddr <= '0;
      gtf_cm_drpdi   <= '0;
      rdata_q        <= '0;
      timeout_q      <= 1'b0;
      stray_rdy      <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (gtf_cm_drprdy && !in_wait) stray_rdy <= 1'b1;
      if (accept) begin
        gtf_cm_drpaddr <= bus.req_addr;
        gtf_cm_drpdi   <= bus.req_wdata;
        rdata_q        <= '0;
        timeout_q      <= 1'b0;
      end
      if (state == RD_WAIT && gtf_cm_drprdy) begin
        rdata_q <= gtf_cm_drpdo;
`ifdef GTF_DRP_RMW_EN
        if (rmw_q) gtf_cm_drpdi <= (gtf_cm_drpdo & ~mask_q) | (gtf_cm_drpdi & mask_q);
`endif
      end else if (in_wait && !gtf_cm_drprdy && expired) begin
        rdata_q   <= '0;
        timeout_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gtf_common_drp_master.sv
// Randomized bench for gtf_common_drp_master against a register-file DRP responder
// and a transaction-level reference model.
module tb_gtf_common_drp_master;
  localparam int TMO = 16;
`ifdef GTF_DRP_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        drpen, drpwe, drprdy, stray;
  logic [15:0] drpaddr, drpdi, drpdo;

  gtf_common_drp_master_if bus();

  gtf_common_drp_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .gtf_cm_drpclk   (clk),
    .gtf_cm_drprst_n (rst_n),
    .bus             (bus),
    .gtf_cm_drpen    (drpen),
    .gtf_cm_drpwe    (drpwe),
    .gtf_cm_drpaddr  (drpaddr),
    .gtf_cm_drpdi    (drpdi),
    .gtf_cm_drpdo    (drpdo),
    .gtf_cm_drprdy   (drprdy),
    .stray_rdy       (stray)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DRP responder: register file, fixed latency per transaction, optional silence.
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  int          pend = 0, lat_g = 1, rd_pulses = 0, wr_pulses = 0;
  bit          silent = 1'b0, stray_req = 1'b0;
  logic [15:0] pend_data = '0, last_addr = '0;

  always @(negedge clk) begin
    drprdy = 1'b0;
    drpdo  = 16'($urandom);
    if (stray_req) begin
      drprdy    = 1'b1;
      stray_req = 1'b0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drprdy = 1'b1;
        drpdo  = pend_data;
      end
    end
    if (drpen) begin
      last_addr = drpaddr;
      if (drpwe) begin
        wr_pulses++;
        if (!silent) mem[drpaddr[7:0]] = drpdi;
      end else begin
        rd_pulses++;
        pend_data = mem[drpaddr[7:0]];
      end
      if (!silent) pend = lat_g;
    end
  end

  // One request from the IDLE state; entered and left on a negedge.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] mask, input int lat, input bit sil, input int stall);
    bit          rmw;
    logic [15:0] pre, exp_rd, exp_mem;
    int          exp_cyc, exp_rdp, exp_wrp, cyc;
    bit          exp_to;
    rmw = RMW_EN && we && (mask != 16'hFFFF);
    pre = ref_mem[addr[7:0]];
    exp_rdp = (!we || rmw) ? 1 : 0;
    if (sil) begin
      exp_to  = 1'b1;
      exp_rd  = 16'h0;
      exp_mem = pre;
      exp_cyc = 2 + TMO;
      exp_wrp = (we && !rmw) ? 1 : 0;
    end else begin
      exp_to  = 1'b0;
      exp_rd  = (we && !rmw) ? 16'h0 : pre;
      exp_mem = !we ? pre : (rmw ? ((pre & ~mask) | (wdata & mask)) : wdata);
      exp_cyc = rmw ? 3 + 2 * lat : 2 + lat;
      exp_wrp = we ? 1 : 0;
    end
    ref_mem[addr[7:0]] = exp_mem;

    lat_g = lat; silent = sil; rd_pulses = 0; wr_pulses = 0;
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_mask = mask;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.req_valid = 1'b0;
    end while (!bus.rsp_valid && cyc < 200);
    chk("rsp_latency", 32'(cyc), 32'(exp_cyc));
    chk("rsp_rdata", {16'b0, bus.rsp_rdata}, {16'b0, exp_rd});
    chk("rsp_timeout", {31'b0, bus.rsp_timeout}, {31'b0, exp_to});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("rsp_hold", {31'b0, bus.rsp_valid}, 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rd_pulses", 32'(rd_pulses), 32'(exp_rdp));
    chk("wr_pulses", 32'(wr_pulses), 32'(exp_wrp));
    if (rd_pulses + wr_pulses > 0) chk("drp_addr", {16'b0, last_addr}, {16'b0, addr});
    chk("reg_value", {16'b0, mem[addr[7:0]]}, {16'b0, exp_mem});
    silent = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, {16'b0, bus.rsp_rdata}, 32'd0);
    chk({tag, "_rsp_timeout"}, {31'b0, bus.rsp_timeout}, 32'd0);
    chk({tag, "_drpen"}, {31'b0, drpen}, 32'd0);
    chk({tag, "_drpwe"}, {31'b0, drpwe}, 32'd0);
    chk({tag, "_drpaddr"}, {16'b0, drpaddr}, 32'd0);
    chk({tag, "_drpdi"}, {16'b0, drpdi}, 32'd0);
    chk({tag, "_stray"}, {31'b0, stray}, 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    bit          seen;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_mask = '0; bus.rsp_ready = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    mem[8'h08] = 16'hA5A5; ref_mem[8'h08] = 16'hA5A5;
    run_txn(1'b0, 16'h0008, 16'h0000, 16'hFFFF, 3, 1'b0, 0);
    run_txn(1'b1, 16'h0010, 16'h1234, 16'hFFFF, 2, 1'b0, 1);
    mem[8'h20] = 16'hABCD; ref_mem[8'h20] = 16'hABCD;
    run_txn(1'b1, 16'h0020, 16'h0050, 16'h00F0, 2, 1'b0, 0);
    run_txn(1'b0, 16'h0011, 16'h0000, 16'h0000, TMO, 1'b0, 0);
    run_txn(1'b0, 16'h0012, 16'h0000, 16'h0000, 1, 1'b1, 0);
    run_txn(1'b1, 16'h0021, 16'hFFFF, 16'h0F0F, 1, 1'b1, 0);
    run_txn(1'b0, 16'h0020, 16'h0000, 16'h0000, 1, 1'b0, 0);
    chk("stray_clear", {31'b0, stray}, 32'd0);

    // Completion while idle
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_set", {31'b0, stray}, 32'd1);
    run_txn(1'b0, 16'h0003, 16'h0000, 16'h0000, 2, 1'b0, 0);
    chk("stray_sticky", {31'b0, stray}, 32'd1);

    // Reset while waiting on a read
    silent = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0008;
    bus.req_wdata = 16'h5A5A; bus.req_mask = 16'hFFFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    silent = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", {31'b0, seen}, 32'd0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
              int'($urandom_range(1, 6)), ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
